led_pattern_player: RTL

LED_PATTERN_PLAYER -- requirements
Module: led_pattern_player

---
 rtl/led_pattern_player_pkg.sv | 30 +++
 rtl/led_pattern_player_tick_gen.sv | 36 +++
 rtl/led_pattern_player.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_pattern_player_pkg.sv
// Shared types and word layout for the LED pattern player.
// Also holds the table-pointer wrap helper.
package led_pattern_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int ADDR_W   = 14;
  localparam int PAT_LSB  = 0;
  localparam int PAT_MSB  = 9;
  localparam int HOLD_LSB = 16;
  localparam int HOLD_MSB = 31;
  localparam int PAT_W    = PAT_MSB - PAT_LSB + 1;
  localparam int HOLD_W   = HOLD_MSB - HOLD_LSB + 1;

  function automatic logic [ADDR_W-1:0] next_ptr(
    input logic [ADDR_W-1:0] ptr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] last
  );
    logic [ADDR_W-1:0] w_one;
    w_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    return (ptr == last) ? base : (ptr + w_one);
  endfunction

endpackage

// File: rtl/led_pattern_player_tick_gen.sv
// Hold-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
// A clear forces the count back to zero so every hold starts on a fresh tick period.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [31:0] LAST_CNT = 32'(TICK_DIV - 1);

  logic [31:0] r_cnt;

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (i_clear) begin
      r_cnt <= 32'd0;
    end else if (i_en) begin
      if (r_cnt == LAST_CNT) begin
        r_cnt <= 32'd0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/led_pattern_player.sv
// Plays a table of {hold, pattern} words from on-chip memory onto ten LEDs.
// A word with hold count zero ends the table (loop back or finish).
module led_pattern_player
  import led_pattern_player_pkg::*;
#(
  parameter int          BASE_WORD = 0,
  parameter int          LAST_WORD = 9999,
  parameter int unsigned TICK_DIV  = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [PAT_W-1:0]  leds,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_WORD);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [HOLD_W-1:0]   r_hold;
  logic [PAT_W-1:0]    r_leds;
  logic                r_done;
  logic                r_cs;
  logic                r_busy;
  logic                w_tick;
  logic                w_stop_active;
  logic                w_end_marker;
  logic [HOLD_W-1:0]   w_word_hold;
  logic                w_unused_bits;

  assign w_word_hold   = mem_readdata[HOLD_MSB:HOLD_LSB];
  assign w_end_marker  = (w_word_hold == 16'd0);
  assign w_stop_active = stop && (r_state != ST_IDLE);
  assign w_unused_bits = ^mem_readdata[HOLD_LSB-1:PAT_MSB+1];

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != ST_HOLD),
    .i_en    (r_state == ST_HOLD),
    .o_tick  (w_tick)
  );

  // Next-state decode; stop overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    if (w_stop_active) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = (start && !stop) ? ST_FETCH : ST_IDLE;
        ST_FETCH: w_next_state = ST_LATCH;
        ST_LATCH: begin
          if (w_end_marker) begin
            w_next_state = loop_en ? ST_FETCH : ST_IDLE;
          end else begin
            w_next_state = ST_HOLD;
          end
        end
        ST_HOLD:  w_next_state = (w_tick && (r_hold == 16'd1)) ? ST_FETCH : ST_HOLD;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= BASE_ADDR;
      r_hold  <= 16'd0;
      r_leds  <= 10'd0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cs    <= (w_next_state == ST_FETCH);
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= 1'b0;
      if (w_stop_active) begin
        r_leds <= 10'd0;
        r_hold <= 16'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !stop) r_ptr <= BASE_ADDR;
          end
          ST_LATCH: begin
            if (!w_end_marker) begin
              r_leds <= mem_readdata[PAT_MSB:PAT_LSB];
              r_hold <= w_word_hold;
              r_ptr  <= next_ptr(r_ptr, BASE_ADDR, LAST_ADDR);
            end else if (loop_en) begin
              r_ptr <= BASE_ADDR;
            end else begin
              r_done <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (w_tick) r_hold <= r_hold - 16'd1;
          end
          default: begin
            r_hold <= r_hold;
          end
        endcase
      end
    end
  end

  assign mem_address    = r_ptr;
  assign mem_chipselect = r_cs;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign leds           = r_leds;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
